// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path constants and types
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int RX_FIFO_DEPTH_LOG2 = 3;
  typedef logic [RX_FIFO_DEPTH_LOG2:0] rx_fifo_ptr_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-facing write strobe, consumer handshake and status
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int width = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
);
  logic [width-1:0] in_data;
  logic in_valid;
  logic [width-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [DEPTH_LOG2:0] fill_level;
  logic full;
  logic empty;
  logic overflow;
  logic clr_overflow;
  modport slave(
    input in_data, in_valid, out_ready, clr_overflow,
    output out_data, out_valid, fill_level, full, empty, overflow
  );
  modport master(
    output in_data, in_valid, out_ready, clr_overflow,
    input out_data, out_valid, fill_level, full, empty, overflow
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: write-enabled register array with combinational read
module uart_fifo_mem import uart_pkg::*; #(
  parameter int width = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic clk,
  input  logic we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [width-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [width-1:0] rdata
);
  logic [width-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through receive buffer with sticky overflow
module uart_rx_fifo import uart_pkg::*; #(
  parameter int width = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input logic clk,
  input logic rst_n,
  uart_rx_fifo_if.slave bus
);
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [width-1:0] rdata;
  logic pop, push, drop;
  always_comb begin
    bus.empty = wr_ptr == rd_ptr;
    bus.full = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
               (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    bus.fill_level = wr_ptr - rd_ptr;
    bus.out_valid = !bus.empty;
    bus.out_data = bus.empty ? '0 : rdata;
    pop = bus.out_valid && bus.out_ready;
    push = bus.in_valid && (!bus.full || pop);
    drop = bus.in_valid && bus.full && !pop;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      bus.overflow <= drop || (bus.overflow && !bus.clr_overflow);
    end
  uart_fifo_mem #(.width(width), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr[DEPTH_LOG2-1:0]),
    .wdata(bus.in_data),
    .raddr(rd_ptr[DEPTH_LOG2-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vector table, corner sequences and random run against a queue model
module tb_uart_rx_fifo;
  import uart_pkg::*;
  localparam int DEPTH = 8;
  typedef struct {
    logic iv;
    logic [7:0] d;
    logic ordy;
    logic clr;
    logic ev;
    logic [7:0] ed;
    logic [3:0] efill;
    logic efull;
    logic eovf;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  int errs = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic m_ovf = 0;
  bit model_ok = 0;
  logic s_valid, s_full, s_empty, s_ovf;
  logic [7:0] s_data;
  rx_fifo_ptr_t s_fill;
  vec_t tbl[$];
  uart_rx_fifo_if #(.width(8), .DEPTH_LOG2(3)) bus();
  uart_rx_fifo #(.width(8), .DEPTH_LOG2(3)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t v(logic iv, logic [7:0] d, logic ordy, logic clr,
                             logic ev, logic [7:0] ed, logic [3:0] efill, logic efull, logic eovf);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.clr = clr;
    r.ev = ev; r.ed = ed; r.efill = efill; r.efull = efull; r.eovf = eovf;
    return r;
  endfunction
  task automatic cyc(input logic rn, input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    bit mpop, mfull, set;
    @(negedge clk);
    rst_n = rn;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    bus.clr_overflow = clr;
    s_valid = bus.out_valid; s_data = bus.out_data; s_fill = bus.fill_level;
    s_full = bus.full; s_empty = bus.empty; s_ovf = bus.overflow;
    if (model_ok) begin
      chk("m_valid", s_valid, q.size() != 0);
      chk("m_data", s_data, q.size() != 0 ? q[0] : 8'h00);
      chk("m_fill", s_fill, q.size());
      chk("m_full", s_full, q.size() == DEPTH);
      chk("m_empty", s_empty, q.size() == 0);
      chk("m_ovf", s_ovf, m_ovf);
    end
    if (!rn) begin
      q.delete();
      m_ovf = 0;
      model_ok = 1;
    end else begin
      mpop = q.size() != 0 && ordy;
      mfull = q.size() == DEPTH;
      set = iv && mfull && !mpop;
      if (mpop) void'(q.pop_front());
      if (iv && !set) q.push_back(d);
      m_ovf = set || (m_ovf && !clr);
    end
  endtask
  initial begin
    logic [7:0] sent[$];
    logic [7:0] got[$];
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; bus.clr_overflow = 0;
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(1, 8'h3C, 0, 0, 1, 8'hA5, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 8'hA5, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'hA5, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h3C, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(1, 8'(i + 1), 0, 0, i != 0, i != 0 ? 8'h01 : 8'h00, 4'(i), 0, 0));
    tbl.push_back(v(1, 8'hFF, 0, 0, 1, 8'h01, 8, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 8'h01, 8, 1, 1));
    tbl.push_back(v(1, 8'h09, 1, 0, 1, 8'h01, 8, 1, 1));
    tbl.push_back(v(0, 8'h00, 0, 1, 1, 8'h02, 8, 1, 1));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h02, 8, 1, 0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'(3 + k), 4'(7 - k), 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(1, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("t%0d_valid", i), s_valid, tbl[i].ev);
      chk($sformatf("t%0d_data", i), s_data, tbl[i].ed);
      chk($sformatf("t%0d_fill", i), s_fill, tbl[i].efill);
      chk($sformatf("t%0d_full", i), s_full, tbl[i].efull);
      chk($sformatf("t%0d_empty", i), s_empty, tbl[i].efill == 0);
      chk($sformatf("t%0d_ovf", i), s_ovf, tbl[i].eovf);
    end
    for (int i = 0; i < 8; i++) cyc(1, 1, 8'h40 + 8'(i), 0, 0);
    cyc(1, 1, 8'hEE, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("set_wins_ovf", s_ovf, 1);
    chk("set_wins_fill", s_fill, 8);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'h60 + 8'(i), 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pre_rst_fill", s_fill, 5);
    cyc(0, 1, 8'h77, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("post_rst_empty", s_empty, 1);
    chk("post_rst_valid", s_valid, 0);
    chk("post_rst_fill", s_fill, 0);
    cyc(1, 1, 8'h5A, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("after_rst_valid", s_valid, 1);
    chk("after_rst_data", s_data, 8'h5A);
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 42; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      cyc(1, i < 40, d, 1, 0);
      if (i < 40) sent.push_back(d);
      if (s_valid) got.push_back(s_data);
      chk("stream_fill_le1", s_fill <= 1, 1);
      chk("stream_no_ovf", s_ovf, 0);
    end
    chk("stream_count", got.size(), 40);
    foreach (got[i]) if (i < sent.size()) chk($sformatf("stream_%0d", i), got[i], sent[i]);
    for (int i = 0; i < 600; i++) begin
      bit wr_heavy;
      wr_heavy = (i / 150) % 2 == 0;
      cyc($urandom_range(0, 99) != 0,
          wr_heavy ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
          8'($urandom),
          wr_heavy ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0);
    end
    cyc(1, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
